// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module   : program_loader
// Purpose  : Boot-time loader in front of the CPU Fetch stage. Takes a framed
//            byte stream (LEN_LO, LEN_HI, 4*N payload bytes, CHK), assembles
//            little-endian instruction words, writes them to instruction
//            memory and holds the CPU in reset until a load finishes with a
//            matching XOR checksum.
// Ports    : clock            - system clock
//            reset            - asynchronous, active-low reset
//            loadRequest      - pulse, start a new load (IDLE/DONE/ERROR only)
//            byteIn/byteValid - stream data and its valid flag
//            byteReady        - loader takes byteIn on this cycle's edge
//            imemWriteEnable  - one-cycle instruction memory write strobe
//            imemWriteAddress - word address of the write
//            imemWriteData    - assembled instruction word
//            cpuHold          - active-high reset towards the CPU
//            loadDone         - last load succeeded (level)
//            loadError        - last load failed (level)
//            wordsLoaded      - words written by the current/last load
// Revision : 1.0 - initial release
// ============================================================================
module program_loader #(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int BYTE_WIDTH        = 8,
  parameter int IMEM_ADDR_WIDTH   = 8,
  parameter int COUNT_WIDTH       = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         loadRequest,
  input  logic [BYTE_WIDTH-1:0]        byteIn,
  input  logic                         byteValid,
  output logic                         byteReady,
  output logic                         imemWriteEnable,
  output logic [IMEM_ADDR_WIDTH-1:0]   imemWriteAddress,
  output logic [INSTRUCTION_WIDTH-1:0] imemWriteData,
  output logic                         cpuHold,
  output logic                         loadDone,
  output logic                         loadError,
  output logic [COUNT_WIDTH-1:0]       wordsLoaded
);

  localparam int c_lanes     = INSTRUCTION_WIDTH / BYTE_WIDTH;
  localparam int c_laneWidth = $clog2(c_lanes);
  localparam logic [c_laneWidth-1:0] c_lastLane = c_laneWidth'(c_lanes - 1);
  // One extra bit so a length equal to the memory depth is representable.
  localparam logic [COUNT_WIDTH:0]   c_memDepth = (COUNT_WIDTH + 1)'(2 ** IMEM_ADDR_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_CHECK  = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } loaderState_t;

  loaderState_t                 r_state;
  logic [c_laneWidth-1:0]       r_lane;
  logic [INSTRUCTION_WIDTH-1:0] r_wordBuf;
  logic [BYTE_WIDTH-1:0]        r_checksum;
  logic [BYTE_WIDTH-1:0]        r_lenLo;
  logic [COUNT_WIDTH-1:0]       r_length;

  logic                         w_accept;
  logic [COUNT_WIDTH-1:0]       w_lengthIn;
  logic [INSTRUCTION_WIDTH-1:0] w_assembled;
  logic [COUNT_WIDTH-1:0]       w_nextWords;

  assign w_accept    = byteValid && byteReady;
  assign w_lengthIn  = COUNT_WIDTH'({byteIn, r_lenLo});
  assign w_nextWords = wordsLoaded + COUNT_WIDTH'(1);

  // The top lane is taken straight from the bus so the word can be written
  // on the edge after its last byte without an extra buffering cycle.
  always_comb begin
    w_assembled = r_wordBuf;
    w_assembled[(c_lanes - 1) * BYTE_WIDTH +: BYTE_WIDTH] = byteIn;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state          <= S_IDLE;
      r_lane           <= '0;
      r_wordBuf        <= '0;
      r_checksum       <= '0;
      r_lenLo          <= '0;
      r_length         <= '0;
      byteReady        <= 1'b0;
      imemWriteEnable  <= 1'b0;
      imemWriteAddress <= '0;
      imemWriteData    <= '0;
      cpuHold          <= 1'b1;
      loadDone         <= 1'b0;
      loadError        <= 1'b0;
      wordsLoaded      <= '0;
    end else begin
      imemWriteEnable <= 1'b0;
      unique case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (loadRequest) begin
            r_state     <= S_LEN_LO;
            byteReady   <= 1'b1;
            cpuHold     <= 1'b1;
            loadDone    <= 1'b0;
            loadError   <= 1'b0;
            wordsLoaded <= '0;
            r_checksum  <= '0;
            r_lane      <= '0;
          end
        end
        S_LEN_LO: begin
          if (w_accept) begin
            r_lenLo <= byteIn;
            r_state <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (w_accept) begin
            r_length <= w_lengthIn;
            if (w_lengthIn == '0) begin
              r_state <= S_CHECK;
            end else if ({1'b0, w_lengthIn} > c_memDepth) begin
              r_state   <= S_ERROR;
              byteReady <= 1'b0;
              loadError <= 1'b1;
            end else begin
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_checksum <= r_checksum ^ byteIn;
            if (r_lane == c_lastLane) begin
              r_lane           <= '0;
              imemWriteEnable  <= 1'b1;
              imemWriteAddress <= wordsLoaded[IMEM_ADDR_WIDTH-1:0];
              imemWriteData    <= w_assembled;
              wordsLoaded      <= w_nextWords;
              if (w_nextWords == r_length) begin
                r_state <= S_CHECK;
              end
            end else begin
              r_wordBuf[r_lane * BYTE_WIDTH +: BYTE_WIDTH] <= byteIn;
              r_lane <= r_lane + 1'b1;
            end
          end
        end
        S_CHECK: begin
          if (w_accept) begin
            byteReady <= 1'b0;
            if (byteIn == r_checksum) begin
              r_state  <= S_DONE;
              cpuHold  <= 1'b0;
              loadDone <= 1'b1;
            end else begin
              r_state   <= S_ERROR;
              loadError <= 1'b1;
            end
          end
        end
        default: begin
          r_state   <= S_IDLE;
          byteReady <= 1'b0;
          cpuHold   <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_program_loader
// Purpose  : Self-checking bench for program_loader. Frames are built from
//            payload byte queues; the expected instruction words, checksum
//            and final status are computed from the frame contents and
//            compared against the memory write port and status outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_program_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        loadRequest = 1'b0;
  logic [7:0]  byteIn = 8'h00;
  logic        byteValid = 1'b0;
  logic        byteReady;
  logic        imemWriteEnable;
  logic [7:0]  imemWriteAddress;
  logic [31:0] imemWriteData;
  logic        cpuHold;
  logic        loadDone;
  logic        loadError;
  logic [15:0] wordsLoaded;

  int          assertCount = 0;
  int          failCount = 0;
  logic [31:0] expWords[$];
  int          expAddr = 0;
  logic [7:0]  payload[$];
  logic [31:0] monWord;

  program_loader #(
    .INSTRUCTION_WIDTH(32),
    .BYTE_WIDTH       (8),
    .IMEM_ADDR_WIDTH  (8),
    .COUNT_WIDTH      (16)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .loadRequest     (loadRequest),
    .byteIn          (byteIn),
    .byteValid       (byteValid),
    .byteReady       (byteReady),
    .imemWriteEnable (imemWriteEnable),
    .imemWriteAddress(imemWriteAddress),
    .imemWriteData   (imemWriteData),
    .cpuHold         (cpuHold),
    .loadDone        (loadDone),
    .loadError       (loadError),
    .wordsLoaded     (wordsLoaded)
  );

  always #5 clock = ~clock;

  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Every write must match the next expected word, in address order.
  always @(negedge clock) begin
    if (reset === 1'b1 && imemWriteEnable === 1'b1) begin
      if (expWords.size() == 0) begin
        checkValue("unexpectedWrite", 32'd1, 32'd0);
      end else begin
        monWord = expWords.pop_front();
        checkValue("writeAddr", 32'(imemWriteAddress), 32'(expAddr));
        checkValue("writeData", imemWriteData, monWord);
        expAddr++;
        checkValue("wordsAtWrite", 32'(wordsLoaded), 32'(expAddr));
      end
    end
  end

  task automatic sendByte(input logic [7:0] b, input int maxGap);
    int waited;
    waited = 0;
    repeat ($urandom_range(maxGap)) begin
      byteValid = 1'b0;
      @(negedge clock);
    end
    byteValid = 1'b1;
    byteIn    = b;
    while (byteReady !== 1'b1 && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    if (waited >= 50) begin
      checkValue("byteReadyTimeout", 32'd0, 32'd1);
      byteValid = 1'b0;
    end else begin
      @(negedge clock);
    end
  endtask

  task automatic pulseRequest();
    loadRequest = 1'b1;
    @(negedge clock);
    loadRequest = 1'b0;
    expAddr = 0;
    expWords.delete();
    checkValue("holdAfterRequest", 32'(cpuHold), 32'd1);
    checkValue("readyAfterRequest", 32'(byteReady), 32'd1);
    checkValue("doneClearedOnRequest", 32'(loadDone), 32'd0);
    checkValue("errorClearedOnRequest", 32'(loadError), 32'd0);
    checkValue("wordsClearedOnRequest", 32'(wordsLoaded), 32'd0);
  endtask

  task automatic fillRandom(input int n);
    payload.delete();
    for (int i = 0; i < 4 * n; i++) payload.push_back(8'($urandom));
  endtask

  task automatic runFrame(input int n, input logic [7:0] chkMask, input int maxGap, input string name);
    logic [7:0] xorSum;
    logic       ok;
    xorSum = 8'h00;
    pulseRequest();
    if (n <= 256) begin
      for (int i = 0; i < n; i++)
        expWords.push_back({payload[4*i+3], payload[4*i+2], payload[4*i+1], payload[4*i]});
      for (int i = 0; i < 4 * n; i++) xorSum = xorSum ^ payload[i];
    end
    sendByte(n[7:0], maxGap);
    sendByte(n[15:8], maxGap);
    if (n > 256) begin
      checkValue({name, "/errAfterLenHi"}, 32'(loadError), 32'd1);
    end else begin
      for (int i = 0; i < 4 * n; i++) sendByte(payload[i], maxGap);
      sendByte(xorSum ^ chkMask, maxGap);
    end
    byteValid = 1'b0;
    repeat (2) @(negedge clock);
    ok = (n <= 256) && (chkMask == 8'h00);
    checkValue({name, "/loadDone"}, 32'(loadDone), 32'(ok));
    checkValue({name, "/loadError"}, 32'(loadError), 32'(!ok));
    checkValue({name, "/cpuHold"}, 32'(cpuHold), 32'(!ok));
    checkValue({name, "/wordsLoaded"}, 32'(wordsLoaded), (n <= 256) ? 32'(n) : 32'd0);
    checkValue({name, "/byteReady"}, 32'(byteReady), 32'd0);
    checkValue({name, "/missingWrites"}, 32'(expWords.size()), 32'd0);
  endtask

  task automatic checkResetValues(input string name);
    checkValue({name, "/byteReady"}, 32'(byteReady), 32'd0);
    checkValue({name, "/writeEnable"}, 32'(imemWriteEnable), 32'd0);
    checkValue({name, "/writeAddress"}, 32'(imemWriteAddress), 32'd0);
    checkValue({name, "/writeData"}, imemWriteData, 32'd0);
    checkValue({name, "/cpuHold"}, 32'(cpuHold), 32'd1);
    checkValue({name, "/loadDone"}, 32'(loadDone), 32'd0);
    checkValue({name, "/loadError"}, 32'(loadError), 32'd0);
    checkValue({name, "/wordsLoaded"}, 32'(wordsLoaded), 32'd0);
  endtask

  task automatic midDataReset();
    fillRandom(4);
    pulseRequest();
    for (int i = 0; i < 4; i++)
      expWords.push_back({payload[4*i+3], payload[4*i+2], payload[4*i+1], payload[4*i]});
    sendByte(8'd4, 0);
    sendByte(8'd0, 0);
    for (int i = 0; i < 3; i++) sendByte(payload[i], 0);
    loadRequest = 1'b1;          // arrives in DATA and must be ignored
    sendByte(payload[3], 0);
    loadRequest = 1'b0;
    sendByte(payload[4], 0);
    sendByte(payload[5], 0);
    byteValid = 1'b0;
    checkValue("midData/wordsLoaded", 32'(wordsLoaded), 32'd1);
    checkValue("midData/byteReady", 32'(byteReady), 32'd1);
    #2 reset = 1'b0;
    #1 checkResetValues("asyncReset");
    @(negedge clock);
    reset = 1'b1;
    expWords.delete();
    repeat (2) @(negedge clock);
    checkValue("idleAfterReset/byteReady", 32'(byteReady), 32'd0);
    checkValue("idleAfterReset/cpuHold", 32'(cpuHold), 32'd1);
  endtask

  initial begin
    int         n;
    logic [7:0] mask;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checkResetValues("reset");
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checkValue("idle/byteReady", 32'(byteReady), 32'd0);
    checkValue("idle/cpuHold", 32'(cpuHold), 32'd1);

    payload = {8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    runFrame(2, 8'h00, 0, "basic");
    runFrame(2, 8'h01, 0, "badChk");
    runFrame(2, 8'h00, 1, "retry");

    runFrame(257, 8'h00, 0, "tooLong");

    fillRandom(256);
    runFrame(256, 8'h00, 2, "fullMem");

    payload.delete();
    runFrame(0, 8'h00, 0, "empty");

    for (int k = 0; k < 8; k++) begin
      n    = int'($urandom_range(12, 1));
      mask = ($urandom_range(3) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
      fillRandom(n);
      runFrame(n, mask, int'($urandom_range(2)), "random");
    end

    midDataReset();
    fillRandom(1);
    runFrame(1, 8'h00, 0, "afterReset");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
`default_nettype wire
